// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared ALU definitions: default widths, opcodes, sequencer states, flags-byte layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

   localparam int ALU_DATA_WIDTH = 8;
   localparam int ALU_OP_WIDTH   = 6;

   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_AND = 6'b100100;
   localparam logic [5:0] OP_OR  = 6'b100101;
   localparam logic [5:0] OP_XOR = 6'b100110;
   localparam logic [5:0] OP_NOR = 6'b100111;
   localparam logic [5:0] OP_SRA = 6'b000011;
   localparam logic [5:0] OP_SRL = 6'b000010;

   typedef enum logic [2:0] {
      WAIT_A   = 3'd0,
      WAIT_B   = 3'd1,
      WAIT_OP  = 3'd2,
      EXEC     = 3'd3,
      SEND_RES = 3'd4,
      SEND_FLG = 3'd5
   } seq_state_t;

   // Bit positions inside the flags byte returned after the result byte.
   localparam int FLAG_ZERO_BIT = 0;
   localparam int FLAG_OVF_BIT  = 1;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of the rx byte stream, tx valid/ready stream and ALU operand/result bus.
// Latency: n/a (wiring only).
// Backpressure: tx side is valid/ready; rx side is a strobe with no backpressure.
interface alu_cmd_sequencer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int OP_WIDTH   = 6
);
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic [DATA_WIDTH-1:0] alu_a;
   logic [DATA_WIDTH-1:0] alu_b;
   logic [OP_WIDTH-1:0]   alu_op;
   logic [DATA_WIDTH-1:0] alu_result;
   logic                  alu_zero;
   logic                  alu_overflow;

   // Sequencer side.
   modport master (
      input  rx_data, rx_valid, tx_ready, alu_result, alu_zero, alu_overflow,
      output tx_data, tx_valid, alu_a, alu_b, alu_op
   );

   // Environment side: byte source, byte sink and the ALU.
   modport slave (
      output rx_data, rx_valid, tx_ready, alu_result, alu_zero, alu_overflow,
      input  tx_data, tx_valid, alu_a, alu_b, alu_op
   );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Parses A/B/opcode byte frames, drives the ALU, returns result then flags bytes.
// Latency: op-byte strobe at cycle n -> result byte valid at cycle n+2.
// Backpressure: tx holds until ready; rx bytes arriving while busy are dropped (rx_drop).
// Optional inter-byte timeout enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH     = ALU_DATA_WIDTH,
   parameter int OP_WIDTH       = ALU_OP_WIDTH,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                clk,
   input  logic                rst_n,
   alu_cmd_sequencer_if.master bus,
   output logic                busy,
   output logic                rx_drop,
   output logic                timeout_err
);

   seq_state_t state, state_nxt;

   logic [DATA_WIDTH-1:0] alu_a_q, alu_b_q, tx_data_q, flags_q, flags_nxt;
   logic [OP_WIDTH-1:0]   alu_op_q;
   logic                  tx_valid_q;
   logic                  load_a, load_b, load_op, do_exec, res_xfer, flg_xfer;
   logic                  tmo_fire;

   assign bus.alu_a    = alu_a_q;
   assign bus.alu_b    = alu_b_q;
   assign bus.alu_op   = alu_op_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.tx_valid = tx_valid_q;

   assign busy = (state == EXEC) || (state == SEND_RES) || (state == SEND_FLG);

`ifdef ALU_SEQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] idle_cnt;
   logic             in_partial;
   logic             timeout_err_q;

   assign in_partial  = (state == WAIT_B) || (state == WAIT_OP);
   // An rx byte on the expiry cycle is accepted instead of aborting the frame.
   assign tmo_fire    = in_partial && !bus.rx_valid && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign timeout_err = timeout_err_q;

   // Count consecutive idle cycles inside a partial frame; any byte or exit clears it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idle_cnt      <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         timeout_err_q <= tmo_fire;
         if (in_partial && !bus.rx_valid && !tmo_fire)
            idle_cnt <= idle_cnt + 1'b1;
         else
            idle_cnt <= '0;
      end
   end
`else
   assign tmo_fire    = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= WAIT_A;
      else        state <= state_nxt;
   end

   // Next-state and per-cycle datapath enables.
   always_comb begin
      state_nxt = state;
      load_a    = 1'b0;
      load_b    = 1'b0;
      load_op   = 1'b0;
      do_exec   = 1'b0;
      res_xfer  = 1'b0;
      flg_xfer  = 1'b0;
      flags_nxt = '0;
      flags_nxt[FLAG_ZERO_BIT] = bus.alu_zero;
      flags_nxt[FLAG_OVF_BIT]  = bus.alu_overflow;
      case (state)
         WAIT_A: begin
            if (bus.rx_valid) begin
               load_a    = 1'b1;
               state_nxt = WAIT_B;
            end
         end
         WAIT_B: begin
            if (bus.rx_valid) begin
               load_b    = 1'b1;
               state_nxt = WAIT_OP;
            end else if (tmo_fire) begin
               state_nxt = WAIT_A;
            end
         end
         WAIT_OP: begin
            if (bus.rx_valid) begin
               load_op   = 1'b1;
               state_nxt = EXEC;
            end else if (tmo_fire) begin
               state_nxt = WAIT_A;
            end
         end
         EXEC: begin
            do_exec   = 1'b1;
            state_nxt = SEND_RES;
         end
         SEND_RES: begin
            if (tx_valid_q && bus.tx_ready) begin
               res_xfer  = 1'b1;
               state_nxt = SEND_FLG;
            end
         end
         SEND_FLG: begin
            if (tx_valid_q && bus.tx_ready) begin
               flg_xfer  = 1'b1;
               state_nxt = WAIT_A;
            end
         end
         default: state_nxt = WAIT_A;
      endcase
   end

   // Operand, result/flags and tx registers; operands persist until the next frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= '0;
         tx_data_q  <= '0;
         flags_q    <= '0;
         tx_valid_q <= 1'b0;
         rx_drop    <= 1'b0;
      end else begin
         rx_drop <= busy && bus.rx_valid;
         if (load_a)  alu_a_q  <= bus.rx_data;
         if (load_b)  alu_b_q  <= bus.rx_data;
         if (load_op) alu_op_q <= bus.rx_data[OP_WIDTH-1:0];
         if (do_exec) begin
            tx_data_q  <= bus.alu_result;
            flags_q    <= flags_nxt;
            tx_valid_q <= 1'b1;
         end
         if (res_xfer) tx_data_q  <= flags_q;
         if (flg_xfer) tx_valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU peer.
// Latency: checks result byte two cycles after the opcode strobe.
// Backpressure: exercises held tx data under tx_ready=0 and rx drops while busy.
module tb_alu_cmd_sequencer;
   import alu_pkg::*;

   logic clk;
   logic rst_n;
   logic busy, rx_drop, timeout_err;
   int   checks = 0;
   int   passes = 0;

   alu_cmd_sequencer_if #(.DATA_WIDTH(8), .OP_WIDTH(6)) bus ();

   alu_cmd_sequencer #(
      .DATA_WIDTH(8),
      .OP_WIDTH(6),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .busy(busy),
      .rx_drop(rx_drop),
      .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU peer.
   logic [7:0] m_res;
   logic       m_ovf;
   always_comb begin
      m_res = 8'h00;
      m_ovf = 1'b0;
      case (bus.alu_op)
         OP_ADD: begin
            m_res = bus.alu_a + bus.alu_b;
            m_ovf = (bus.alu_a[7] == bus.alu_b[7]) && (m_res[7] != bus.alu_a[7]);
         end
         OP_SUB: begin
            m_res = bus.alu_a - bus.alu_b;
            m_ovf = (bus.alu_a[7] != bus.alu_b[7]) && (m_res[7] != bus.alu_a[7]);
         end
         OP_AND: m_res = bus.alu_a & bus.alu_b;
         OP_OR:  m_res = bus.alu_a | bus.alu_b;
         OP_XOR: m_res = bus.alu_a ^ bus.alu_b;
         OP_NOR: m_res = ~(bus.alu_a | bus.alu_b);
         OP_SRL: m_res = bus.alu_b >> bus.alu_a[2:0];
         OP_SRA: m_res = $unsigned($signed(bus.alu_b) >>> bus.alu_a[2:0]);
         default: m_res = 8'h00;
      endcase
   end
   assign bus.alu_result   = m_res;
   assign bus.alu_zero     = (m_res == 8'h00);
   assign bus.alu_overflow = m_ovf;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      tick();
      bus.rx_valid = 1'b0;
   endtask

   // Waits (bounded) for a tx byte, checks it, and lets it transfer with tx_ready=1.
   task automatic get_tx(input string tag, input logic [7:0] exp);
      int n;
      n = 0;
      while (!bus.tx_valid && n < 50) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, 32'(bus.tx_valid), 32'd1);
      chk(tag, 32'(bus.tx_data), 32'(exp));
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst_n        = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      bus.tx_ready = 1'b1;
      tick();
      tick();
      chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      chk("rst_tx_data",  32'(bus.tx_data),  32'd0);
      chk("rst_alu_a",    32'(bus.alu_a),    32'd0);
      chk("rst_busy",     32'(busy),         32'd0);
      chk("rst_rx_drop",  32'(rx_drop),      32'd0);
      chk("rst_tmo",      32'(timeout_err),  32'd0);
      rst_n = 1'b1;
      tick();

      // 1: ADD 5+3, latency check.
      send(8'h05);
      send(8'h03);
      send(8'h20);
      chk("t1_exec_busy",  32'(busy),         32'd1);
      chk("t1_exec_valid", 32'(bus.tx_valid), 32'd0);
      chk("t1_alu_a",      32'(bus.alu_a),    32'h05);
      chk("t1_alu_b",      32'(bus.alu_b),    32'h03);
      chk("t1_alu_op",     32'(bus.alu_op),   32'h20);
      tick();
      chk("t1_lat_valid",  32'(bus.tx_valid), 32'd1);
      chk("t1_res",        32'(bus.tx_data),  32'h08);
      tick();
      chk("t1_flg_valid",  32'(bus.tx_valid), 32'd1);
      chk("t1_flg",        32'(bus.tx_data),  32'h00);
      tick();
      chk("t1_done_valid", 32'(bus.tx_valid), 32'd0);
      chk("t1_done_busy",  32'(busy),         32'd0);
      chk("t1_hold_a",     32'(bus.alu_a),    32'h05);

      // 2: SUB 5-5 -> zero flag.
      send(8'h05);
      send(8'h05);
      send(8'h22);
      get_tx("t2_res", 8'h00);
      get_tx("t2_flg", 8'h01);

      // 3: ADD 0x7F+1 -> signed overflow; upper opcode bits ignored.
      send(8'h7F);
      send(8'h01);
      send(8'hE0);
      chk("t3_op_trunc", 32'(bus.alu_op), 32'h20);
      get_tx("t3_res", 8'h80);
      get_tx("t3_flg", 8'h02);

      // 4: backpressure during SEND_RES plus a dropped rx byte.
      bus.tx_ready = 1'b0;
      send(8'h05);
      send(8'h03);
      send(8'h20);
      tick();
      repeat (2) begin
         chk("t4_hold_valid", 32'(bus.tx_valid), 32'd1);
         chk("t4_hold_data",  32'(bus.tx_data),  32'h08);
         tick();
      end
      send(8'hAA);
      chk("t4_drop_pulse", 32'(rx_drop),      32'd1);
      chk("t4_drop_data",  32'(bus.tx_data),  32'h08);
      chk("t4_drop_a",     32'(bus.alu_a),    32'h05);
      tick();
      chk("t4_drop_end",   32'(rx_drop),      32'd0);
      chk("t4_still_vld",  32'(bus.tx_valid), 32'd1);
      chk("t4_still_data", 32'(bus.tx_data),  32'h08);
      bus.tx_ready = 1'b1;
      get_tx("t4_res", 8'h08);
      get_tx("t4_flg", 8'h00);
      send(8'h10);
      send(8'h01);
      send(8'h22);
      get_tx("t4_next_res", 8'h0F);
      get_tx("t4_next_flg", 8'h00);

      // 5: reset after byte A discards the partial frame.
      send(8'h33);
      chk("t5_a_loaded", 32'(bus.alu_a), 32'h33);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t5_rst_a",     32'(bus.alu_a),    32'd0);
      chk("t5_rst_b",     32'(bus.alu_b),    32'd0);
      chk("t5_rst_op",    32'(bus.alu_op),   32'd0);
      chk("t5_rst_valid", 32'(bus.tx_valid), 32'd0);
      chk("t5_rst_busy",  32'(busy),         32'd0);
      send(8'h09);
      send(8'h04);
      send(8'h22);
      chk("t5_new_a", 32'(bus.alu_a), 32'h09);
      get_tx("t5_res", 8'h05);
      get_tx("t5_flg", 8'h00);

      // 6: inter-byte idle behaviour.
`ifdef ALU_SEQ_TIMEOUT_EN
      send(8'h11);
      repeat (15) tick();
      chk("t6_pre_tmo",  32'(timeout_err), 32'd0);
      tick();
      chk("t6_tmo",      32'(timeout_err), 32'd1);
      chk("t6_tmo_a",    32'(bus.alu_a),   32'h11);
      tick();
      chk("t6_tmo_end",  32'(timeout_err), 32'd0);
      send(8'h0F);
      send(8'hF0);
      send(8'h25);
`else
      send(8'h0F);
      repeat (20) tick();
      chk("t6_no_tmo",   32'(timeout_err), 32'd0);
      send(8'hF0);
      send(8'h25);
`endif
      get_tx("t6_res", 8'hFF);
      get_tx("t6_flg", 8'h00);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
